ibus_line_responder: RTL
========================

# ibus_line_responder

Instruction-bus responder that serves `ibus_req_t` fetch requests from the instruction fetch stage and returns one 32-bit instruction per request on `ibus_resp_t`. It sits between the fetch stage and a variable-latency 64-bit backing memory port. It keeps a one-line (8-byte) buffer, so the second instruction of an aligned pair is served without a memory access. It also checks alignment and address range, and reports fetch faults.

## Interface
Parameters:
- `MEM_BASE`, default `64'h8000_0000`: lowest fetchable address.
- `MEM_SIZE`, default `64'h1000_0000`: fetchable window size in bytes. An address is legal iff `MEM_BASE <= addr < MEM_BASE+MEM_SIZE`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ibus_req`  in  `ibus_req_t`  `valid` plus `addr` (u64), driven by the fetch stage.
- `ibus_resp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data` (u32).
- `fetch_fault`  out  1  qualifies a response as misaligned or out-of-range; `data`=0 when set.
- `flush`  in  1  invalidates the line buffer (fence.i / CSR write).
- `mem_req`  out  1  backing read request; held high until `mem_ack`.
- `mem_addr`  out  64  8-byte-aligned read address; stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  64  read data.

## Operation
- Registered state:
  - FSM: IDLE, MEM_WAIT, RESP.
  - Captured request address `cap_addr`.
  - Line buffer: `buf_valid`, `buf_tag` (`addr[63:3]`), `buf_data` (64 bits).
- Word select for all responses: `addr[2]`=0 gives `[31:0]`; 1 gives `[63:32]`.
- IDLE, `ibus_req.valid`=1: capture `addr`, then the first matching case applies:
  - Misaligned (`addr[1:0]!=0`) or out-of-range: go to RESP with `fetch_fault`=1, `data`=0. No memory access.
  - Buffer hit (`buf_valid` && tag match && !`flush`): go to RESP with the selected word.
  - Otherwise: go to MEM_WAIT. Drive `mem_req`=1, `mem_addr`={`addr[63:3]`,3'b0}.
- MEM_WAIT, `mem_ack`=1:
  - Fill the buffer: `buf_valid`=!`flush`, tag, data.
  - Drop `mem_req`.
  - If `ibus_req.valid` && `ibus_req.addr==cap_addr`: go to RESP with the selected word from `mem_rdata`.
  - Otherwise (the request was abandoned or redirected): go to IDLE with no response.
- RESP: `addr_ok`=`data_ok`=1 for exactly this cycle. The request is ignored in this cycle. Next state is IDLE.
- `flush` in any state clears `buf_valid` on the next edge. A fill in the same cycle is also invalidated. A response already in progress is still delivered.
- `ibus_resp.data` and `fetch_fault` hold their last value outside RESP. Only `addr_ok`/`data_ok` pulse.

## Timing
- Reset values:
  - State IDLE, `buf_valid`=0.
  - `ibus_resp` all zero, `fetch_fault`=0.
  - `mem_req`=0, `mem_addr`=0.
- Reset is asynchronous. It drops `mem_req` immediately mid-transaction. A `mem_ack` arriving after reset while in IDLE is ignored.
- Fault latency and hit latency: request sampled at edge T, response visible in cycle T+1.
- Miss latency:
  - `mem_req` is high from cycle T+1.
  - `mem_ack` arrives in cycle A.
  - Response is visible in cycle A+1.
  - Minimum total: 2 cycles, when `mem_ack` arrives in T+1.
- Back-to-back requests: after RESP in cycle R, the earliest next request is sampled at the end of R+1. Throughput is at most one response per 2 cycles.
- Exactly one `mem_req` transaction is outstanding at a time, and it is never cancelled.
- The initiator must hold `valid`/`addr` until it sees `addr_ok&data_ok`. Changing `addr` while the response is pending abandons the request (see MEM_WAIT).

## Test plan
- Cold miss then pair hit:
  - Stimulus: request `0x8000_0000`, with `mem_ack` 3 cycles after `mem_req` and `mem_rdata=64'h00A0_0093_0010_0513`.
  - Required: `data=0x0010_0513` one cycle after `mem_ack`.
  - Stimulus: then request `0x8000_0004`.
  - Required: `data=0x00A0_0093` in the next cycle, with `mem_req` never asserted.
- Fault cases:
  - Request `0x8000_0002` gives `fetch_fault`=1, `data`=0, 1-cycle latency, no `mem_req`.
  - Request `0x7FFF_FFFC` gives the same.
- Abandoned miss:
  - Stimulus: request `0x8000_0010`, then drop `valid` before `mem_ack`.
  - Required: `mem_req` stays high until ack, no `addr_ok`, and the buffer fills.
  - Stimulus: a later request to `0x8000_0014`.
  - Required: it hits with 1-cycle latency.
- Redirect mid-miss:
  - Stimulus: `addr` changes `0x8000_0020`→`0x8000_0100` during MEM_WAIT.
  - Required: no response for the old address, then a fresh miss issued with `mem_addr=0x8000_0100`.
- Flush:
  - Stimulus: fill the line at `0x8000_0000`, assert `flush` 1 cycle, then request `0x8000_0004`.
  - Required: a new `mem_req`.
  - Stimulus: `flush` coincident with `mem_ack`.
  - Required: response delivered, but `buf_valid`=0 afterwards.
- Reset mid-miss:
  - Stimulus: assert `rst` while `mem_req`=1.
  - Required: all outputs return to zero immediately, and a stray `mem_ack` after reset produces no response.

Source files
------------

// File: rtl/ibus_line_responder.sv
// Instruction-bus responder with a one-line (8-byte) fetch buffer in front of a
// variable-latency 64-bit memory port. It also reports misaligned and out-of-range fetches.
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_line_responder
  import ibus_pkg::*;
#(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  ibus_req_t   ibus_req,
  output ibus_resp_t  ibus_resp,
  output logic        fetch_fault,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: the fetch stage holds valid/addr until it sees addr_ok&data_ok.
  // Those two strobes pulse together for one cycle (RESP). The memory side
  // holds mem_req/mem_addr until mem_ack, a single-cycle pulse that carries mem_rdata.
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [63:0]   cap_addr;
  logic          buf_valid;
  logic [60:0]   buf_tag;
  logic [63:0]   buf_data;
  logic [31:0]   resp_data;
  logic          resp_fault;
  logic          req_bad;
  logic          req_hit;
  logic          still_wanted;

  function automatic logic [31:0] sel_word(input logic [63:0] line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

  always_comb begin
    req_bad      = (ibus_req.addr[1:0] != 2'b00) ||
                   (ibus_req.addr < MEM_BASE) ||
                   (ibus_req.addr >= MEM_BASE + MEM_SIZE);
    req_hit      = buf_valid && (buf_tag == ibus_req.addr[63:3]) && !flush;
    still_wanted = ibus_req.valid && (ibus_req.addr == cap_addr);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ibus_req.valid) begin
          if (req_bad || req_hit) state_d = RESP;
          else                    state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) state_d = still_wanted ? RESP : IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr   <= '0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= '0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      if (flush) buf_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ibus_req.valid) begin
            cap_addr <= ibus_req.addr;
            if (req_bad) begin
              resp_data  <= '0;
              resp_fault <= 1'b1;
            end else if (req_hit) begin
              resp_data  <= sel_word(buf_data, ibus_req.addr[2]);
              resp_fault <= 1'b0;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {ibus_req.addr[63:3], 3'b000};
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            // A flush in the ack cycle must also kill the line being filled.
            buf_valid <= !flush;
            buf_tag   <= cap_addr[63:3];
            buf_data  <= mem_rdata;
            mem_req   <= 1'b0;
            if (still_wanted) begin
              resp_data  <= sel_word(mem_rdata, cap_addr[2]);
              resp_fault <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ibus_resp.addr_ok = (state_q == RESP);
    ibus_resp.data_ok = (state_q == RESP);
    ibus_resp.data    = resp_data;
    fetch_fault       = resp_fault;
    dbg_state         = state_q;
  end

endmodule
